// File: rtl/kp_pkg.sv
// Shared definitions for the multi-scale keypoint scanner.
//   KP_BORDER   : border width (rows/columns) removed when KP_BORDER_MASK_EN
//                 is defined.
//   kp_state_e  : scanner FSM states.
//   kp_rec_t    : keypoint record (row, col, scale) at generous fixed widths.
//   kp_w()      : index width helper, never smaller than 1 bit.
package kp_pkg;

  localparam int KP_BORDER = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ROW = 2'd1,
    ST_SCAN     = 2'd2,
    ST_DONE     = 2'd3
  } kp_state_e;

  typedef struct packed {
    logic [15:0] row;
    logic [15:0] col;
    logic [7:0]  scale;
  } kp_rec_t;

  function automatic int kp_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/kp_find_first.sv
// Lowest-set-bit encoder.
//   vec : input bit vector, width W
//   idx : position of the lowest set bit (0 when nothing is set)
//   any : at least one bit of vec is set
module kp_find_first
  import kp_pkg::*;
#(
  parameter int  W  = 32,
  localparam int IW = kp_w(W)
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from the top down so the last hit, the lowest index, wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypoint_scan_multiscale.sv
// Multi-scale keypoint scanner. Accepts one row of per-scale extremum flags
// at a time, then emits every set flag as a (row, col, scale) keypoint,
// scale 0 first and lowest column first, one per cycle under kp_ready
// backpressure. A per-frame keypoint budget saturates kp_count and sets a
// sticky overflow flag; rows after the overflow are accepted and dropped.
//
// Optional build macro KP_BORDER_MASK_EN: when defined, flags within
// KP_BORDER of any frame edge are cleared as the row is latched.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : one-cycle frame start (ignored outside IDLE)
//   row_valid/row_ready   : row handshake; row_flags[s*COLS +: COLS] = scale s
//   kp_valid/kp_ready     : keypoint handshake; kp_row, kp_col, kp_scale
//   kp_count              : keypoints emitted in the current frame
//   overflow              : sticky budget-exceeded flag
//   done                  : one-cycle end-of-frame pulse
module keypoint_scan_multiscale
  import kp_pkg::*;
#(
  parameter int  COLS       = 640,
  parameter int  ROWS       = 480,
  parameter int  NUM_SCALES = 2,
  parameter int  MAX_KP     = 2048,
  localparam int RW         = kp_w(ROWS),
  localparam int CW         = kp_w(COLS),
  localparam int SW         = kp_w(NUM_SCALES),
  localparam int KW         = $clog2(MAX_KP + 1),
  localparam int FW         = NUM_SCALES * COLS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          row_valid,
  output logic          row_ready,
  input  logic [FW-1:0] row_flags,
  output logic          kp_valid,
  input  logic          kp_ready,
  output logic [RW-1:0] kp_row,
  output logic [CW-1:0] kp_col,
  output logic [SW-1:0] kp_scale,
  output logic [KW-1:0] kp_count,
  output logic          overflow,
  output logic          done
);

  localparam int IW  = kp_w(FW);
  localparam int RCW = $clog2(ROWS + 1);

  kp_state_e      state_q, state_d;
  logic [FW-1:0]  pending_q;
  logic [RW-1:0]  cur_row_q;
  logic [RCW-1:0] row_cnt_q;
  logic [KW-1:0]  kp_count_q;
  logic           overflow_q;

  logic [IW-1:0]  ff_idx;
  logic           ff_any;
  logic [FW-1:0]  row_latch;
  logic           row_acc;
  logic           budget_full;

  kp_find_first #(
    .W (FW)
  ) u_find_first (
    .vec (pending_q),
    .idx (ff_idx),
    .any (ff_any)
  );

  assign row_acc     = row_valid && row_ready;
  assign budget_full = (kp_count_q == KW'(MAX_KP));

`ifdef KP_BORDER_MASK_EN
  // row_cnt_q is the index of the row being accepted this cycle.
  logic [FW-1:0] col_keep;
  logic          row_keep;

  always_comb begin
    col_keep = '0;
    for (int s = 0; s < NUM_SCALES; s++) begin
      for (int c = 0; c < COLS; c++) begin
        col_keep[s*COLS + c] = (c >= KP_BORDER) && (c < COLS - KP_BORDER);
      end
    end
  end

  assign row_keep  = (int'(row_cnt_q) >= KP_BORDER) &&
                     (int'(row_cnt_q) < ROWS - KP_BORDER);
  assign row_latch = row_keep ? (row_flags & col_keep) : '0;
`else
  assign row_latch = row_flags;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. An exhausted (or discarded) row costs exactly one
  // SCAN cycle before moving on.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (start)   state_d = ST_WAIT_ROW;
      ST_WAIT_ROW: if (row_acc) state_d = ST_SCAN;
      ST_SCAN: begin
        if (!ff_any) begin
          state_d = (cur_row_q == RW'(ROWS - 1)) ? ST_DONE : ST_WAIT_ROW;
        end
      end
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // FSM outputs. A full budget with a pending flag is the overflow
  // condition, so no keypoint is offered in that cycle.
  always_comb begin
    row_ready = (state_q == ST_WAIT_ROW);
    done      = (state_q == ST_DONE);
    kp_valid  = (state_q == ST_SCAN) && ff_any && !budget_full;
  end

  // Split the flat encoder index into scale plane and column.
  always_comb begin
    kp_scale = '0;
    kp_col   = CW'(ff_idx);
    for (int s = 1; s < NUM_SCALES; s++) begin
      if (int'(ff_idx) >= s * COLS) begin
        kp_scale = SW'(s);
        kp_col   = CW'(int'(ff_idx) - s * COLS);
      end
    end
  end

  assign kp_row   = cur_row_q;
  assign kp_count = kp_count_q;
  assign overflow = overflow_q;

  // Row latch, pending-bit retirement and frame counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      cur_row_q  <= '0;
      row_cnt_q  <= '0;
      kp_count_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) && start) begin
        pending_q  <= '0;
        cur_row_q  <= '0;
        row_cnt_q  <= '0;
        kp_count_q <= '0;
        overflow_q <= 1'b0;
      end
      if (row_acc) begin
        // After an overflow the rest of the frame is consumed but dropped.
        pending_q <= overflow_q ? '0 : row_latch;
        cur_row_q <= RW'(row_cnt_q);
        row_cnt_q <= row_cnt_q + RCW'(1);
      end
      if ((state_q == ST_SCAN) && ff_any) begin
        if (budget_full) begin
          overflow_q <= 1'b1;
          pending_q  <= '0;
        end else if (kp_ready) begin
          pending_q  <= pending_q & ~(FW'(1) << ff_idx);
          kp_count_q <= kp_count_q + KW'(1);
        end
      end
    end
  end

endmodule
